uart_inst_rx: RTL

UART receiver that lets a host deliver 8-bit instruction words over the serial line instead of through the switches and the execute button. It samples the board's `RsRx` line (8N1, LSB first, idle high) and emits one `inst_wd`/`inst_vld` pulse per good frame. The output pair has the same meaning and timing as the button-driven instruction path and feeds the same instruction mux into the execution datapath. It is the receive-side counterpart of the design's `RsTx` result transmitter.

---
 rtl/uart_inst_rx_if.sv | 20 ++
 rtl/uart_inst_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_inst_rx_if.sv
// Serial instruction receive bus: the rx line in, and the received instruction word,
// its strobe and the error/status flags out.
interface uart_inst_rx_if;
  logic       rx;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       frm_err;
  logic       par_err;
  logic       busy;

  modport slave (
    input  rx,
    output inst_wd, inst_vld, frm_err, par_err, busy
  );

  modport master (
    output rx,
    input  inst_wd, inst_vld, frm_err, par_err, busy
  );
endinterface

// File: rtl/uart_inst_rx.sv
// UART instruction receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined): delivers one
// inst_wd/inst_vld pulse per good frame, sharing the timing of the button instruction path.
module uart_inst_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  uart_inst_rx_if.slave bus
);

  localparam int C  = CLK_HZ / BAUD;
  localparam int CW = $clog2(C);
  localparam logic [CW-1:0] HALF_M1 = CW'(C / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(C - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    wd_q, wd_nxt;
  logic          rx_s1, rx_s2;
  logic          armed, disarm;
  logic          vld_q, vld_nxt;
  logic          fe_q, fe_nxt;
  logic          tick;
`ifdef UART_RX_PARITY_EN
  logic          pb, pb_nxt;
  logic          pe_q, pe_nxt;
`endif

  assign tick = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    wd_nxt    = wd_q;
    vld_nxt   = 1'b0;
    fe_nxt    = 1'b0;
    disarm    = 1'b0;
`ifdef UART_RX_PARITY_EN
    pb_nxt    = pb;
    pe_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (armed && !rx_s2) begin
          state_nxt = START;
          cnt_nxt   = HALF_M1;
        end
      end
      START: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!rx_s2) begin
          state_nxt = DATA;
          cnt_nxt   = FULL_M1;
          idx_nxt   = 3'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          // Right shift: the first (LSB) bit ends up in bit 0 after eight samples.
          sh_nxt  = {rx_s2, sh[7:1]};
          cnt_nxt = FULL_M1;
          idx_nxt = idx + 1'b1;
          if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          pb_nxt    = rx_s2;
          cnt_nxt   = FULL_M1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          cnt_nxt   = FULL_M1;
          state_nxt = DONE;
          // A low stop bit also disarms, so a held-low break reports only once.
          if (!rx_s2) begin
            fe_nxt = 1'b1;
            disarm = 1'b1;
          end
`ifdef UART_RX_PARITY_EN
          else if (^{sh, pb}) begin
            pe_nxt = 1'b1;
          end
`endif
          else begin
            vld_nxt = 1'b1;
            wd_nxt  = sh;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      armed <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      idx   <= 3'd0;
      wd_q  <= 8'h00;
      vld_q <= 1'b0;
      fe_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_q  <= 1'b0;
`endif
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      if (disarm)     armed <= 1'b0;
      else if (rx_s2) armed <= 1'b1;
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      wd_q  <= wd_nxt;
      vld_q <= vld_nxt;
      fe_q  <= fe_nxt;
`ifdef UART_RX_PARITY_EN
      pe_q  <= pe_nxt;
`endif
    end
  end

  // Sampled data bits need no reset; only the published word does.
  always_ff @(posedge clk) begin
    sh <= sh_nxt;
`ifdef UART_RX_PARITY_EN
    pb <= pb_nxt;
`endif
  end

  assign bus.inst_wd  = wd_q;
  assign bus.inst_vld = vld_q;
  assign bus.frm_err  = fe_q;
  assign bus.busy     = (state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.par_err  = pe_q;
`else
  assign bus.par_err  = 1'b0;
`endif

endmodule
